// File: rtl/sramc_result_reader.sv
// Drains the four sramC banks after the systolic array finishes, streaming one
// NBANK*DATA_W row word per row address over a valid/ready port.
module sramc_result_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int NBANK  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         cfg_base,
    input  logic [ADDR_W:0]           cfg_len,
    output logic                      rd_en,
    output logic [NBANK-1:0]          rd_wen,
    output logic [NBANK*ADDR_W-1:0]   rd_addr,
    input  logic [NBANK*DATA_W-1:0]   rd_q,
    output logic [NBANK*DATA_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int WORD_W = NBANK * DATA_W;
    localparam int LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [LEN_W-1:0]    remaining_r;
    logic                inflight_r;
    logic                inflight_last_r;
    logic [WORD_W-1:0]   buf_data_r [2];
    logic                buf_last_r [2];
    logic                rd_ptr_r;
    logic                wr_ptr_r;
    logic [1:0]          occ_r;
    logic [1:0]          load_s;
    logic                space_s;
    logic                issue_s;
    logic                pop_s;
    logic                last_issue_s;

    assign pop_s        = out_valid & out_ready;
    assign load_s       = occ_r + {1'b0, inflight_r};
    assign last_issue_s = (remaining_r == LEN_W'(1));

    // Space check: a pop this cycle frees one slot before the next read lands.
    always_comb begin
        space_s = 1'b0;
        issue_s = 1'b0;
        if (pop_s) begin
            space_s = (load_s < 2'd3);
        end else begin
            space_s = (load_s < 2'd2);
        end
        if ((state_r == S_READ) && (remaining_r != LEN_W'(0)) && space_s) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (cfg_len == LEN_W'(0)) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_READ;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                if (issue_s && last_issue_s) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_READ;
                end
            end
            S_DRAIN: begin
                if (pop_s && buf_last_r[rd_ptr_r]) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Row address and remaining-row counter; config is captured only from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r          <= '0;
            remaining_r     <= '0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            if ((state_r == S_IDLE) && start) begin
                addr_r      <= cfg_base;
                remaining_r <= cfg_len;
            end else if (issue_s) begin
                addr_r      <= addr_r + ADDR_W'(1);
                remaining_r <= remaining_r - LEN_W'(1);
            end
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s & last_issue_s;
        end
    end

    // Two-entry row buffer; the write slot equals the popped slot when full,
    // so push and pop together are safe at any occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_r[i] <= '0;
                buf_last_r[i] <= 1'b0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (inflight_r) begin
                buf_data_r[wr_ptr_r] <= rd_q;
                buf_last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({inflight_r, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign rd_en     = issue_s;
    assign rd_wen    = {NBANK{1'b1}};
    assign rd_addr   = {NBANK{addr_r}};
    assign out_valid = (occ_r != 2'd0);
    assign out_data  = buf_data_r[rd_ptr_r];
    assign out_last  = out_valid & buf_last_r[rd_ptr_r];
    assign busy      = (state_r != S_IDLE);
    assign done      = (state_r == S_DONE);

endmodule

// File: tb/tb_sramc_result_reader.sv
// Scoreboard bench for sramc_result_reader with a behavioural four-bank sramC
// whose bank b at row a holds the byte (4a+b) mod 256.
module tb_sramc_result_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] cfg_base = 11'd0;
    logic [11:0] cfg_len = 12'd0;
    logic        rd_en;
    logic [3:0]  rd_wen;
    logic [43:0] rd_addr;
    logic [31:0] rd_q = 32'd0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    logic [32:0] exp_q [$];
    logic [10:0] exp_addr = 11'd0;
    int issued = 0;
    int accepted = 0;
    logic ready_toggle = 1'b0;
    logic ready_level = 1'b0;
    logic [3:0] ready_pat = 4'b1001;
    int phase = 0;
    logic stall_hold = 1'b0;
    logic [32:0] held = 33'd0;

    sramc_result_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .rd_en(rd_en), .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_q(rd_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] row_word(input logic [10:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) begin
            w[b*8 +: 8] = 8'((4 * int'(a) + b) & 255);
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // sramC model: one-cycle read latency, each bank decodes its own address field.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int b = 0; b < 4; b++) begin
                rd_q[b*8 +: 8] <= 8'((4 * int'(rd_addr[b*11 +: 11]) + b) & 255);
            end
        end
    end

    // Sink ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_toggle ? ready_pat[phase] : ready_level;
            phase = (phase + 1) % 4;
        end
    end

    // Monitor: read-address sequence, issue rule, handshake stability, scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_hold = 1'b0;
        end else begin
            if (stall_hold) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", {31'd0, out_last, out_data}, {31'd0, held});
            end
            if (rd_en) begin
                chk("rd_addr", {20'd0, rd_addr}, {20'd0, {4{exp_addr}}});
                exp_addr = exp_addr + 11'd1;
                chk("issue_room", 64'((issued - accepted - int'(out_valid & out_ready)) < 2), 64'd1);
                issued++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", {31'd0, out_last, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("row", {31'd0, out_last, out_data}, {31'd0, exp_q.pop_front()});
                end
                accepted++;
            end
            stall_hold = out_valid && !out_ready;
            held = {out_last, out_data};
        end
    end

    task automatic do_start(input logic [10:0] base, input logic [11:0] len);
        @(negedge clk);
        start = 1'b1;
        cfg_base = base;
        cfg_len = len;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({(i == int'(len) - 1), row_word(base + 11'(i))});
        end
        exp_addr = base;
        @(posedge clk);
        #2;
        start = 1'b0;
        cfg_base = 11'h155;
        cfg_len = 12'd5;
    endtask

    // Waits for done (bounded); exp_k < 0 skips the timing check, inj_k injects a stray start.
    task automatic wait_done(input string tag, input int exp_k, input logic exp_rd1, input int inj_k);
        int k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk({tag, "_rd_en_c1"}, {63'd0, rd_en}, {63'd0, exp_rd1});
                chk({tag, "_busy_c1"}, {63'd0, busy}, 64'd1);
            end
            #1;
            start = (k == inj_k);
            cfg_base = 11'h100;
            cfg_len = 12'd3;
            if (done) break;
        end
        start = 1'b0;
        if (exp_k >= 0) chk({tag, "_done_cycle"}, 64'(k), 64'(exp_k));
        else chk({tag, "_done_seen"}, 64'(k < 400), 64'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        chk({tag, "_rows_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int iss0;
        #12;
        chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
        chk("rst_rd_wen", {60'd0, rd_wen}, 64'hF);
        chk("rst_outs", {51'd0, out_valid, out_last, busy, done, rd_addr[7:0], 1'b0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_level = 1'b1;
        repeat (2) @(negedge clk);

        // 1: base 0, four rows, sink always ready
        do_start(11'd0, 12'd4);
        wait_done("t1", 7, 1'b1, 0);

        // 2: eight rows under 1,0,0,1 backpressure
        ready_toggle = 1'b1;
        do_start(11'd8, 12'd8);
        wait_done("t2", -1, 1'b1, 0);
        ready_toggle = 1'b0;

        // 3: address wrap at the top of the bank
        do_start(11'h7FE, 12'd4);
        wait_done("t3", 7, 1'b1, 0);

        // 4: zero-length transfer
        iss0 = issued;
        do_start(11'd3, 12'd0);
        wait_done("t4", 1, 1'b0, 0);
        chk("t4_no_reads", 64'(issued - iss0), 64'd0);

        // 5: reset while two rows sit in the buffer
        ready_level = 1'b0;
        do_start(11'h40, 12'd8);
        repeat (3) @(posedge clk);
        #3;
        chk("t5_buffered", {62'd0, out_valid, busy}, 64'd3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", {60'd0, out_valid, rd_en, busy, done}, 64'd0);
        chk("t5_rst_data", {31'd0, out_last, out_data}, 64'd0);
        chk("t5_rst_addr", {20'd0, rd_addr}, 64'd0);
        exp_q.delete();
        issued = 0;
        accepted = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        ready_level = 1'b1;
        do_start(11'h50, 12'd2);
        wait_done("t5", 5, 1'b1, 0);

        // 6: stray start mid-transfer is ignored
        do_start(11'h20, 12'd4);
        wait_done("t6", 7, 1'b1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
